// File: rtl/sccb_reg_reader.sv
// SCCB register read master for the OV5640 (16-bit address, 8-bit data).
// Latency: 200 quarter-bit periods (200*QDIV clk) from accept to rd_valid; 44 quarters on an early NACK.
// Backpressure: rd_ready high only when idle; rd_req while busy is dropped, never queued.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   rd_req/rd_ready    request handshake, rd_addr latched on accept
//   rd_valid/rd_data   one-cycle completion pulse with the read byte
//   rd_nack            slave NACK seen during an address/device byte
//   scl_oe/sda_oe      open-drain pull-down enables (1 = drive low)
//   sda_i              SDA pin level, already synchronised
//
// Optional feature: define SCCB_ACK_CHECK_EN to sample the slave ACK slot of every
// transmitted byte and abort to STOP on NACK. Without it the ACK slot is ignored and
// rd_nack is tied low.
module sccb_reg_reader #(
    parameter int         CLK_FREQ_HZ  = 27_000_000,
    parameter int         SCCB_FREQ_HZ = 100_000,
    parameter logic [6:0] DEV_ADDR     = 7'h3C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_nack,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i
);

    localparam int QDIV_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int CW       = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);

    // The completion pulse is issued on the STOP2 exit edge, so the "done" step
    // of the sequence lives in that transition rather than in its own state.
    typedef enum logic [2:0] {
        S_IDLE, S_START1, S_TX, S_STOP1, S_BUSFREE, S_START2, S_RX, S_STOP2
    } state_t;

    state_t      state, nxt_state;
    logic [1:0]  q, nxt_q;              // quarter within the current 4q slot
    logic [3:0]  bit_idx, nxt_bit;      // 0..7 data bits, 8 = ACK/NACK slot
    logic [1:0]  byte_sel, nxt_sel;     // 0: dev write, 1: addr hi, 2: addr lo, 3: dev read
    logic [CW-1:0] cnt;
    logic [15:0] addr_q;
    logic [7:0]  rx_shift;
    logic        nack_q;
    logic        tick, accept, finish;

    assign tick   = (cnt == QLAST);
    assign accept = (state == S_IDLE) && rd_req;

    function automatic logic [7:0] byte_of(input logic [1:0] sel, input logic [15:0] a);
        case (sel)
            2'd0:    return {DEV_ADDR, 1'b0};
            2'd1:    return a[15:8];
            2'd2:    return a[7:0];
            default: return {DEV_ADDR, 1'b1};
        endcase
    endfunction

    // Line levels for a given phase, returned as {scl_oe, sda_oe}.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] qq,
                                              input logic [3:0] b, input logic [7:0] byt);
        logic [1:0] d;
        d = 2'b00;
        case (st)
            S_START1, S_START2: begin
                case (qq)
                    2'd0:       d = 2'b00;
                    2'd1, 2'd2: d = 2'b01;
                    default:    d = 2'b11;
                endcase
            end
            S_STOP1, S_STOP2: begin
                case (qq)
                    2'd0:       d = 2'b11;
                    2'd1, 2'd2: d = 2'b01;
                    default:    d = 2'b00;
                endcase
            end
            S_TX: begin
                d[1] = ~qq[1];
                // ACK slot releases SDA so the slave can answer
                d[0] = (b[3] == 1'b0) ? ~byt[3'd7 - b[2:0]] : 1'b0;
            end
            S_RX:    d[1] = ~qq[1];
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_q     = q + 2'd1;
        nxt_bit   = bit_idx;
        nxt_sel   = byte_sel;
        finish    = 1'b0;
        if (q == 2'd3) begin
            case (state)
                S_START1: begin nxt_state = S_TX; nxt_bit = 4'd0; nxt_sel = 2'd0; end
                S_START2: begin nxt_state = S_TX; nxt_bit = 4'd0; nxt_sel = 2'd3; end
                S_TX: begin
                    if (bit_idx != 4'd8) begin
                        nxt_bit = bit_idx + 4'd1;
                    end else if (nack_q) begin
                        nxt_state = S_STOP2;
                    end else begin
                        nxt_bit = 4'd0;
                        case (byte_sel)
                            2'd0:    nxt_sel = 2'd1;
                            2'd1:    nxt_sel = 2'd2;
                            2'd2:    nxt_state = S_STOP1;
                            default: nxt_state = S_RX;
                        endcase
                    end
                end
                S_RX: begin
                    if (bit_idx != 4'd8) nxt_bit = bit_idx + 4'd1;
                    else                 nxt_state = S_STOP2;
                end
                S_STOP1:   nxt_state = S_BUSFREE;
                S_BUSFREE: nxt_state = S_START2;
                S_STOP2: begin nxt_state = S_IDLE; finish = 1'b1; end
                default:   nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            q        <= 2'd0;
            bit_idx  <= 4'd0;
            byte_sel <= 2'd0;
            cnt      <= '0;
            addr_q   <= 16'h0000;
            rx_shift <= 8'h00;
            rd_ready <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            cnt      <= (tick || accept) ? '0 : cnt + CW'(1);
            if (state == S_IDLE) begin
                if (rd_req) begin
                    addr_q   <= rd_addr;
                    state    <= S_START1;
                    q        <= 2'd0;
                    bit_idx  <= 4'd0;
                    byte_sel <= 2'd0;
                    rd_ready <= 1'b0;
                    scl_oe   <= 1'b0;
                    sda_oe   <= 1'b0;
                end
            end else if (tick) begin
                // data is valid on the q2->q3 boundary (SCL high since q2)
                if (state == S_RX && q == 2'd2 && bit_idx[3] == 1'b0)
                    rx_shift <= {rx_shift[6:0], sda_i};
                state    <= nxt_state;
                q        <= nxt_q;
                bit_idx  <= nxt_bit;
                byte_sel <= nxt_sel;
                {scl_oe, sda_oe} <= line_drive(nxt_state, nxt_q, nxt_bit, byte_of(nxt_sel, addr_q));
                if (finish) begin
                    rd_valid <= 1'b1;
                    rd_ready <= 1'b1;
                    if (!nack_q) rd_data <= rx_shift;
                end
            end
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nack_q  <= 1'b0;
            rd_nack <= 1'b0;
        end else begin
            if (accept)
                nack_q <= 1'b0;
            else if (tick && state == S_TX && q == 2'd2 && bit_idx == 4'd8 && sda_i)
                nack_q <= 1'b1;
            if (tick && finish)
                rd_nack <= nack_q;
        end
    end
`else
    assign nack_q  = 1'b0;
    assign rd_nack = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_reg_reader.sv
// Bench for sccb_reg_reader with an open-drain SCCB slave model holding a register file.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sccb_reg_reader;

    localparam int QDIV    = 67;
    localparam int TXN_CLK = 200 * QDIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = 16'h0000;
    logic        rd_ready, rd_valid, rd_nack, scl_oe, sda_oe, sda_i;
    logic [7:0]  rd_data;

    logic slave_pull = 1'b0;
    logic scl_line, sda_line;
    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | slave_pull);
    assign sda_i    = sda_line;

    sccb_reg_reader dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_nack(rd_nack),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_data_q[$];
    logic [7:0] exp_bus_q[$];
    logic [7:0] last_good = 8'h00;
    int         b2b_rise_idx, b2b_bus_idx, b2b_rx9_idx;
    bit         nack_all = 1'b0;

    function automatic logic [7:0] regfile(input logic [15:0] a);
        case (a)
            16'h300A: return 8'h56;
            16'h4300: return 8'h61;
            16'h3035: return 8'h11;
            default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // ---------------- slave model ----------------
    logic [7:0]  bus_bytes[$];
    int          scl_rises[$];
    logic        rx9_oe[$];
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    int          sl_bitcnt = 0, sl_byte_n = 0;
    logic [7:0]  sl_shift = 8'h00, sl_rd_data = 8'h00;
    logic [15:0] sl_reg_addr = 16'h0000;
    bit          sl_rd_mode = 1'b0;

    always @(negedge clk) begin : slave_model
        logic [7:0] rdv;
        rdv = regfile(sl_reg_addr);
        prev_scl <= scl_line;
        prev_sda <= sda_line;
        if (scl_line && prev_scl && prev_sda && !sda_line) begin
            sl_bitcnt <= 0; sl_byte_n <= 0; sl_rd_mode <= 1'b0; slave_pull <= 1'b0;
        end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
            sl_bitcnt <= 0; sl_rd_mode <= 1'b0; slave_pull <= 1'b0;
        end else if (scl_line && !prev_scl) begin
            scl_rises.push_back(cyc);
            if (sl_rd_mode) begin
                if (sl_bitcnt == 8) rx9_oe.push_back(sda_oe);
            end else if (sl_bitcnt < 8) begin
                sl_shift <= {sl_shift[6:0], sda_line};
            end
            sl_bitcnt <= sl_bitcnt + 1;
        end else if (!scl_line && prev_scl) begin
            if (sl_rd_mode) begin
                if (sl_bitcnt < 8) slave_pull <= !nack_all && !sl_rd_data[3'(7 - sl_bitcnt)];
                else               slave_pull <= 1'b0;
            end else if (sl_bitcnt == 8) begin
                bus_bytes.push_back(sl_shift);
                slave_pull <= !nack_all;
                if (sl_byte_n == 1) sl_reg_addr[15:8] <= sl_shift;
                if (sl_byte_n == 2) sl_reg_addr[7:0]  <= sl_shift;
                sl_byte_n <= sl_byte_n + 1;
            end else if (sl_bitcnt == 9) begin
                slave_pull <= 1'b0;
                sl_bitcnt  <= 0;
                if (sl_byte_n == 1 && sl_shift == 8'h79) begin
                    sl_rd_mode <= 1'b1;
                    sl_rd_data <= rdv;
                    slave_pull <= !nack_all && !rdv[7];
                end
            end
        end
    end

    // ---------------- helpers (stimulus / bounded wait) ----------------
    task automatic start_read(input logic [15:0] a);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic push_bus(input logic [15:0] a);
        exp_bus_q.push_back(8'h78);
        exp_bus_q.push_back(a[15:8]);
        exp_bus_q.push_back(a[7:0]);
        exp_bus_q.push_back(8'h79);
    endtask

    task automatic wait_valid(input int max_n, output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (n < max_n && !got) begin
            @(negedge clk);
            n++;
            if (rd_valid === 1'b1) got = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rd_ready got %b want 1", rd_ready); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        n_checks++; if (rd_nack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_nack got %b want 0", rd_nack); end
        n_checks++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe got %b want 0", scl_oe); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Read 300A with rd_req held so the next read (4300) is accepted on the rd_valid cycle.
    task automatic test_read_id();
        int n; bit got; int b0; logic [7:0] e, g;
        b0 = bus_bytes.size();
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 16'h300A;
        exp_data_q.push_back(regfile(16'h300A));
        push_bus(16'h300A);
        wait_valid(TXN_CLK + 200, n, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL id_timeout got none want rd_valid"); end
        // first loop negedge follows the accept edge, so clocks = n - 1
        n_checks++; if (n - 1 != TXN_CLK) begin n_fail++; $display("FAIL id_latency got %0d want %0d", n - 1, TXN_CLK); end
        e = exp_data_q.pop_front();
        last_good = e;
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL id_data got %h want %h", rd_data, e); end
        n_checks++; if (rd_nack !== 1'b0) begin n_fail++; $display("FAIL id_nack got %b want 0", rd_nack); end
        for (int i = 0; i < 4; i++) begin
            g = (bus_bytes.size() > b0 + i) ? bus_bytes[b0 + i] : 8'hxx;
            e = exp_bus_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL id_bus_byte%0d got %h want %h", i, g, e); end
        end
        rd_addr      = 16'h4300;
        exp_data_q.push_back(regfile(16'h4300));
        push_bus(16'h4300);
        b2b_rise_idx = scl_rises.size();
        b2b_bus_idx  = bus_bytes.size();
        b2b_rx9_idx  = rx9_oe.size();
        @(negedge clk);
        rd_req = 1'b0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL id_valid_pulse got %b want 0", rd_valid); end
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_ready got %b want 0", rd_ready); end
    endtask

    task automatic test_back_to_back();
        int n; bit got; logic [7:0] e, g; int per;
        wait_valid(TXN_CLK + 200, n, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL b2b_timeout got none want rd_valid"); end
        n_checks++; if (n != TXN_CLK) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", n, TXN_CLK); end
        e = exp_data_q.pop_front();
        last_good = e;
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL b2b_data got %h want %h", rd_data, e); end
        n_checks++; if (rd_nack !== 1'b0) begin n_fail++; $display("FAIL b2b_nack got %b want 0", rd_nack); end
        for (int i = 0; i < 4; i++) begin
            g = (bus_bytes.size() > b2b_bus_idx + i) ? bus_bytes[b2b_bus_idx + i] : 8'hxx;
            e = exp_bus_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_bus_byte%0d got %h want %h", i, g, e); end
        end
        per = (scl_rises.size() > b2b_rise_idx + 1) ? scl_rises[b2b_rise_idx + 1] - scl_rises[b2b_rise_idx] : -1;
        n_checks++; if (per != 4 * QDIV) begin n_fail++; $display("FAIL scl_period got %0d want %0d", per, 4 * QDIV); end
        g[0] = (rx9_oe.size() > b2b_rx9_idx) ? rx9_oe[b2b_rx9_idx] : 1'bx;
        n_checks++; if (g[0] !== 1'b0) begin n_fail++; $display("FAIL rx_nack_slot_sda_oe got %b want 0", g[0]); end
    endtask

    task automatic test_busy_ignore();
        int pulses; logic [7:0] cap, e, g; int b0;
        b0 = bus_bytes.size();
        exp_data_q.push_back(regfile(16'h3808));
        push_bus(16'h3808);
        start_read(16'h3808);
        repeat (20 * QDIV) @(negedge clk);
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", rd_ready); end
        rd_req  = 1'b1;
        rd_addr = 16'h3035;
        repeat (50) @(negedge clk);
        rd_req  = 1'b0;
        rd_addr = 16'hFFFF;
        pulses = 0;
        cap    = 8'hxx;
        for (int i = 0; i < TXN_CLK + 400; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) cap = rd_data;
            end
        end
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL busy_pulses got %0d want 1", pulses); end
        e = exp_data_q.pop_front();
        last_good = e;
        n_checks++; if (cap !== e) begin n_fail++; $display("FAIL busy_data got %h want %h", cap, e); end
        for (int i = 0; i < 4; i++) begin
            g = (bus_bytes.size() > b0 + i) ? bus_bytes[b0 + i] : 8'hxx;
            e = exp_bus_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL busy_bus_byte%0d got %h want %h", i, g, e); end
        end
        n_checks++; if (bus_bytes.size() != b0 + 4) begin n_fail++; $display("FAIL busy_bus_count got %0d want %0d", bus_bytes.size() - b0, 4); end
    endtask

    task automatic test_nack();
        int n; bit got; int b0; logic [7:0] e, g;
        b0 = bus_bytes.size();
        nack_all = 1'b1;
`ifdef SCCB_ACK_CHECK_EN
        exp_data_q.push_back(last_good);
        start_read(16'h300A);
        wait_valid(TXN_CLK + 200, n, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL nack_timeout got none want rd_valid"); end
        n_checks++; if (n != 44 * QDIV) begin n_fail++; $display("FAIL nack_latency got %0d want %0d", n, 44 * QDIV); end
        n_checks++; if (rd_nack !== 1'b1) begin n_fail++; $display("FAIL nack_flag got %b want 1", rd_nack); end
        e = exp_data_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL nack_data_held got %h want %h", rd_data, e); end
        n_checks++; if (bus_bytes.size() != b0 + 1) begin n_fail++; $display("FAIL nack_bus_count got %0d want 1", bus_bytes.size() - b0); end
        g = (bus_bytes.size() > b0) ? bus_bytes[b0] : 8'hxx;
        n_checks++; if (g !== 8'h78) begin n_fail++; $display("FAIL nack_bus_byte0 got %h want 78", g); end
`else
        // nobody drives SDA low in the read phase, so the pull-up reads back all ones
        exp_data_q.push_back(8'hFF);
        push_bus(16'h300A);
        start_read(16'h300A);
        wait_valid(TXN_CLK + 200, n, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL nack_timeout got none want rd_valid"); end
        n_checks++; if (n != TXN_CLK) begin n_fail++; $display("FAIL nack_latency got %0d want %0d", n, TXN_CLK); end
        n_checks++; if (rd_nack !== 1'b0) begin n_fail++; $display("FAIL nack_flag got %b want 0", rd_nack); end
        e = exp_data_q.pop_front();
        n_checks++; if (rd_data !== e) begin n_fail++; $display("FAIL nack_data got %h want %h", rd_data, e); end
        for (int i = 0; i < 4; i++) begin
            g = (bus_bytes.size() > b0 + i) ? bus_bytes[b0 + i] : 8'hxx;
            e = exp_bus_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL nack_bus_byte%0d got %h want %h", i, g, e); end
        end
`endif
        nack_all = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int pulses;
        start_read(16'h3A1B);
        // quarter 45 lies inside the addr[15:8] byte (quarters 40..75)
        repeat (45 * QDIV) @(negedge clk);
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", rd_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_scl_oe got %b want 0", scl_oe); end
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_sda_oe got %b want 0", sda_oe); end
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", rd_ready); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", rd_data); end
        pulses = 0;
        for (int i = 0; i < 170 * QDIV; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_no_valid got %0d want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_back_to_back();
        test_busy_ignore();
        test_nack();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
